booth_ctrl: RTL

//  Sequencing controller for the radix-2 Booth multiplier datapath. Accepts an operand pair over a

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_ctrl_if.sv | 36 +++
 rtl/booth_recode.sv | 18 +
 rtl/booth_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and recode constants for the radix-2 Booth sequencing controller.
package booth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARITH,
    S_SHIFT,
    S_WAIT,
    S_RESP
  } state_t;

  // Codes of {qzero, qneg1} that call for a datapath add or subtract.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the Booth controller.
interface booth_ctrl_if #(
  parameter int unsigned N = 4
) ();

  localparam int unsigned PW = 2 * N;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_multiplicand;
  logic [N-1:0]  in_multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;

  modport master (
    output in_valid,
    output in_multiplicand,
    output in_multiplier,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_product
  );

  modport slave (
    input  in_valid,
    input  in_multiplicand,
    input  in_multiplier,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_product
  );

endinterface

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: maps {qzero, qneg1} to add/sub strobes when enabled.
module booth_recode
  import booth_pkg::*;
(
  input  logic en,
  input  logic qzero,
  input  logic qneg1,
  output logic add,
  output logic sub
);

  logic [1:0] code;

  assign code = {qzero, qneg1};
  assign add  = en && (code == BOOTH_ADD);
  assign sub  = en && (code == BOOTH_SUB);

endmodule

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: accepts operands, steps the datapath N times, holds the product.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  booth_ctrl_if.slave    bus,
  output logic [N-1:0]   dp_multiplicand,
  output logic [N-1:0]   dp_multiplier,
  output logic           load,
  output logic           add,
  output logic           sub,
  output logic           shift,
  output logic           dc,
  input  logic           qzero,
  input  logic           qneg1,
  input  logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned PW = 2 * N;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   iter;
  logic            idle;
  logic            arith_en;
  logic            accept;
  logic            last_iter;
  logic            out_valid_q;
  logic [PW-1:0]   out_product_q;

  assign accept    = bus.in_valid && idle;
  assign last_iter = (iter == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_ARITH;
      S_ARITH: state_nx = S_SHIFT;
      S_SHIFT: state_nx = last_iter ? S_WAIT : S_ARITH;
      S_WAIT:  state_nx = S_RESP;
      S_RESP:  if (out_valid_q && bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore strobes decoded from state; add/sub also depend on the datapath Q bits
  always_comb begin
    idle     = 1'b0;
    load     = 1'b0;
    arith_en = 1'b0;
    shift    = 1'b0;
    dc       = 1'b0;
    busy     = 1'b1;
    unique case (state)
      S_IDLE:  begin idle = 1'b1; busy = 1'b0; end
      S_LOAD:  load = 1'b1;
      S_ARITH: arith_en = 1'b1;
      S_SHIFT: begin shift = 1'b1; dc = !last_iter; end
      default: ;
    endcase
  end

  booth_recode u_recode (
    .en    (arith_en),
    .qzero (qzero),
    .qneg1 (qneg1),
    .add   (add),
    .sub   (sub)
  );

  // Operand, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      iter            <= '0;
      dp_multiplicand <= '0;
      dp_multiplier   <= '0;
      out_valid_q     <= 1'b0;
      out_product_q   <= '0;
    end else begin
      if (accept) begin
        dp_multiplicand <= bus.in_multiplicand;
        dp_multiplier   <= bus.in_multiplier;
        iter            <= CW'(N - 1);
      end else if (state == S_SHIFT && !last_iter) begin
        iter <= iter - CW'(1);
      end

      if (state == S_WAIT) begin
        out_product_q <= product;
        out_valid_q   <= 1'b1;
      end else if (state == S_RESP && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = idle;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;

endmodule
